// File: rtl/serial_ripple_sub.sv
// Bit-serial ripple subtractor: a - b - bin, one bit per clock, LSB first,
// with a start/busy/done handshake and a per-bit borrow vector.
module serial_ripple_sub #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bin,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] diff,
  output logic [SIZE-1:0] borrow,
  output logic            bout
);

  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] a_q, a_d;
  logic [SIZE-1:0] b_q, b_d;
  logic            br_q, br_d;
  logic [SIZE-1:0] diff_q, diff_d;
  logic [SIZE-1:0] borrow_q, borrow_d;

  logic accept;
  logic a_bit, b_bit, d_bit, bo_bit;

  // start is only honoured when no operation is in flight
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  assign a_bit  = a_q[cnt_q];
  assign b_bit  = b_q[cnt_q];
  assign d_bit  = a_bit ^ b_bit ^ br_q;
  assign bo_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    br_d     = br_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (accept) begin
      // Outputs are cleared so partial results never mix with the previous answer
      state_d  = S_RUN;
      cnt_d    = '0;
      a_d      = a;
      b_d      = b;
      br_d     = bin;
      diff_d   = '0;
      borrow_d = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_RUN: begin
          diff_d[cnt_q]   = d_bit;
          borrow_d[cnt_q] = bo_bit;
          br_d            = bo_bit;
          cnt_d           = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign bout   = borrow_q[SIZE-1];

endmodule

// File: tb/tb_serial_ripple_sub.sv
// Bench for serial_ripple_sub: directed vector table, multi-cycle corner
// sequences, exhaustive sweep and random operations against an arithmetic model.
module tb_serial_ripple_sub;

  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [SIZE-1:0] a, b;
  logic            bin;
  logic            busy, done, bout;
  logic [SIZE-1:0] diff, borrow;

  int total = 0;
  int passed = 0;

  serial_ripple_sub #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .bout(bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            bin;
    logic [SIZE-1:0] diff;
    logic [SIZE-1:0] borrow;
    logic            bout;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: diff by modular arithmetic; borrow[i] from comparing the low i+1 bits
  function automatic void model(input int ra, input int rb, input int rbin,
                                output logic [SIZE-1:0] d, output logic [SIZE-1:0] br);
    int m;
    d = SIZE'((ra - rb - rbin) & ((1 << SIZE) - 1));
    for (int i = 0; i < SIZE; i++) begin
      m = (1 << (i + 1)) - 1;
      br[i] = ((ra & m) < ((rb & m) + rbin));
    end
  endfunction

  task automatic run_op(input logic [SIZE-1:0] ta, input logic [SIZE-1:0] tb_,
                        input logic tbin, output int lat, output int bcnt,
                        output logic [SIZE-1:0] rd, output logic [SIZE-1:0] rbr,
                        output logic rbo);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin lat = k; break; end
      a = SIZE'($urandom); b = SIZE'($urandom); bin = 1'($urandom);
    end
    rd = diff; rbr = borrow; rbo = bout;
  endtask

  vec_t vecs[5];

  initial begin
    int lat, bcnt, dcnt;
    logic [SIZE-1:0] rd, rbr, md, mbr;
    logic rbo;

    vecs[0] = '{a: 4'd5,  b: 4'd3,  bin: 1'b0, diff: 4'd2,  borrow: 4'b0010, bout: 1'b0};
    vecs[1] = '{a: 4'd2,  b: 4'd4,  bin: 1'b1, diff: 4'd13, borrow: 4'b1101, bout: 1'b1};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, diff: 4'd15, borrow: 4'b1111, bout: 1'b1};
    vecs[3] = '{a: 4'd15, b: 4'd15, bin: 1'b0, diff: 4'd0,  borrow: 4'b0000, bout: 1'b0};
    vecs[4] = '{a: 4'd7,  b: 4'd2,  bin: 1'b0, diff: 4'd5,  borrow: 4'b0000, bout: 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_borrow", borrow, 0);
    chk("reset_bout", bout, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bcnt, rd, rbr, rbo);
      chk($sformatf("vec%0d_latency", i), lat, SIZE + 1);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, SIZE);
      chk($sformatf("vec%0d_diff", i), rd, vecs[i].diff);
      chk($sformatf("vec%0d_borrow", i), rbr, vecs[i].borrow);
      chk($sformatf("vec%0d_bout", i), rbo, vecs[i].bout);
    end

    // Second start during RUN must be dropped
    @(negedge clk);
    a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    a = 4'd9; b = 4'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcnt = 0; rd = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) begin dcnt++; rd = diff; end
    end
    chk("ignore_start_done_count", dcnt, 1);
    chk("ignore_start_diff", rd, 5);

    // Back-to-back: start held high through DONE
    @(negedge clk);
    a = 4'd5; b = 4'd3; bin = 1'b0; start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    chk("b2b_first_latency", lat, SIZE + 1);
    chk("b2b_first_diff", diff, 2);
    a = 4'd4; b = 4'd3; bin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_no_idle_busy", busy, 1);
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    chk("b2b_second_latency", lat, SIZE + 1);
    chk("b2b_second_diff", diff, 0);
    chk("b2b_second_bout", bout, 0);
    chk("b2b_second_borrow", borrow, 4'b0011);

    // Reset abort at bit 2 of 1-2
    @(negedge clk);
    a = 4'd1; b = 4'd2; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow, 0);
    chk("abort_bout", bout, 0);
    @(negedge clk) rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

    // Exhaustive sweep
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          run_op(SIZE'(ia), SIZE'(ib), 1'(ic), lat, bcnt, rd, rbr, rbo);
          model(ia, ib, ic, md, mbr);
          chk($sformatf("sweep_%0d_%0d_%0d_latency", ia, ib, ic), lat, SIZE + 1);
          chk($sformatf("sweep_%0d_%0d_%0d_diff", ia, ib, ic), rd, md);
          chk($sformatf("sweep_%0d_%0d_%0d_borrow", ia, ib, ic), rbr, mbr);
          chk($sformatf("sweep_%0d_%0d_%0d_bout", ia, ib, ic), rbo, mbr[SIZE-1]);
        end

    // Random operations
    for (int n = 0; n < 40; n++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      rc = int'($urandom_range(1, 0));
      run_op(SIZE'(ra), SIZE'(rb), 1'(rc), lat, bcnt, rd, rbr, rbo);
      model(ra, rb, rc, md, mbr);
      chk($sformatf("rand%0d_diff", n), rd, md);
      chk($sformatf("rand%0d_borrow", n), rbr, mbr);
      chk($sformatf("rand%0d_bout", n), rbo, mbr[SIZE-1]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
